// File: rtl/fifo_push_arbiter_if.sv
// Producer/FIFO handshake bundle for fifo_push_arbiter.
// The arbiter uses the slave modport; producers and the FIFO model use master.
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]                 req_valid_i;
  logic [NUM_REQ-1:0]                 req_last_i;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]                 req_ready_o;
  logic                               fifo_full_i;
  logic                               fifo_push_o;
  logic [DATA_WIDTH-1:0]              fifo_data_o;

  modport master (
    output req_valid_i, req_last_i, req_data_i, fifo_full_i,
    input  req_ready_o, fifo_push_o, fifo_data_o
  );

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, fifo_full_i,
    output req_ready_o, fifo_push_o, fifo_data_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-locking arbiter in front of a single FIFO push port.
// Optional per-requester beat counters are enabled with `define FIFO_ARB_STATS_EN.
module fifo_push_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = 32,
  localparam int IDX_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  input  logic                  flush_i,
  fifo_push_arbiter_if.slave    bus,
  output logic [IDX_WIDTH-1:0]  grant_idx_o,
  output logic                  locked_o
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0] beat_cnt_o
`endif
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_WIDTH-1:0] own_q, own_d;

  logic [IDX_WIDTH-1:0] win_idx;
  logic                 win_found;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic                 sel_any;
  logic                 sel_last;
  logic [NUM_REQ-1:0]   ready;
  logic                 accept;
  int                   cand;
  logic [IDX_WIDTH-1:0] cand_idx;

  function automatic logic [IDX_WIDTH-1:0] wrap_inc(input logic [IDX_WIDTH-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Round-robin scan starting at rr_ptr_q, wrapping at NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_WIDTH'(cand);
      if (!win_found && bus.req_valid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // The locked owner stays selected even while its valid is low.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = win_idx;
    if (state_q == LOCKED) begin
      sel_any = 1'b1;
      sel_idx = own_q;
    end else begin
      sel_any = win_found;
      sel_idx = win_idx;
    end
  end

  assign sel_last = bus.req_last_i[sel_idx];

  // Reset also gates the combinational outputs so nothing is pushed while it is held.
  always_comb begin
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = a_rst_n && sel_any && (sel_idx == IDX_WIDTH'(i)) &&
                 bus.req_valid_i[i] && !bus.fifo_full_i && !flush_i;
    end
  end

  assign accept          = |ready;
  assign bus.req_ready_o = ready;
  assign bus.fifo_push_o = accept;
  assign bus.fifo_data_o = (a_rst_n && sel_any) ? bus.req_data_i[sel_idx] : '0;
  assign grant_idx_o     = !a_rst_n ? '0 : (sel_any ? sel_idx : rr_ptr_q);
  assign locked_o        = (state_q == LOCKED);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    own_d    = own_q;
    if (flush_i) begin
      state_d  = IDLE;
      rr_ptr_d = '0;
      own_d    = '0;
    end else if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (sel_last) begin
            rr_ptr_d = wrap_inc(sel_idx);
          end else begin
            state_d = LOCKED;
            own_d   = sel_idx;
          end
        end
        LOCKED: begin
          if (sel_last) begin
            state_d  = IDLE;
            rr_ptr_d = wrap_inc(own_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      own_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      own_q    <= own_d;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] beat_cnt_q;

  // NOTE: the counter bank is small and architecturally visible, so it is reset explicitly.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      beat_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ready[i] && (beat_cnt_q[i] != 16'hFFFF)) begin
          beat_cnt_q[i] <= beat_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign beat_cnt_o = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed, table-driven bench for fifo_push_arbiter with NUM_REQ=4.
// Beat-counter checks run when FIFO_ARB_STATS_EN is defined.
module tb_fifo_push_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       a_rst_n;
  logic       flush;
  logic [1:0] grant_idx;
  logic       locked;
`ifdef FIFO_ARB_STATS_EN
  logic [NR-1:0][15:0] beat_cnt;
`endif

  int total = 0;
  int bad   = 0;

  fifo_push_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  fifo_push_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .flush_i    (flush),
    .bus        (bus),
    .grant_idx_o(grant_idx),
    .locked_o   (locked)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt_o (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic        full;
    logic [3:0]  ready;
    logic        push;
    logic [1:0]  grant;
    logic        locked;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dat(input int i);
    return 32'hC0DE_0000 + 32'(i) * 32'h111;
  endfunction

  task automatic add(input logic fl, input logic [3:0] v, input logic [3:0] l, input logic fu,
                     input logic [3:0] r, input logic p, input logic [1:0] g, input logic lk,
                     input logic [31:0] d);
    vec_t e;
    e.flush = fl; e.valid = v; e.last = l; e.full = fu;
    e.ready = r; e.push = p; e.grant = g; e.locked = lk; e.data = d;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, input logic [3:0] v, input logic [3:0] l, input logic fu);
    flush           = fl;
    bus.req_valid_i = v;
    bus.req_last_i  = l;
    bus.fifo_full_i = fu;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ready"},  32'(bus.req_ready_o), 32'h0);
    check({tag, ".push"},   32'(bus.fifo_push_o), 32'h0);
    check({tag, ".data"},   bus.fifo_data_o,      32'h0);
    check({tag, ".grant"},  32'(grant_idx),       32'h0);
    check({tag, ".locked"}, 32'(locked),          32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Rotation over four single-beat requesters.
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, dat(0));
    add(0, 4'b1111, 4'b1111, 0, 4'b0010, 1, 2'd1, 0, dat(1));
    add(0, 4'b1111, 4'b1111, 0, 4'b0100, 1, 2'd2, 0, dat(2));
    add(0, 4'b1111, 4'b1111, 0, 4'b1000, 1, 2'd3, 0, dat(3));
    add(0, 4'b1111, 4'b1111, 0, 4'b0001, 1, 2'd0, 0, dat(0));
    // Requester 1 three-beat burst with 0 and 2 competing, then back-to-back to 2.
    add(0, 4'b0111, 4'b0101, 0, 4'b0010, 1, 2'd1, 0, dat(1));
    add(0, 4'b0111, 4'b0101, 0, 4'b0010, 1, 2'd1, 1, dat(1));
    add(0, 4'b0111, 4'b0111, 0, 4'b0010, 1, 2'd1, 1, dat(1));
    add(0, 4'b0101, 4'b0101, 0, 4'b0100, 1, 2'd2, 0, dat(2));
    // Requester 3 burst stalled two cycles by a full FIFO.
    add(0, 4'b1000, 4'b0000, 0, 4'b1000, 1, 2'd3, 0, dat(3));
    add(0, 4'b1001, 4'b0001, 1, 4'b0000, 0, 2'd3, 1, dat(3));
    add(0, 4'b1001, 4'b0001, 1, 4'b0000, 0, 2'd3, 1, dat(3));
    add(0, 4'b1001, 4'b0001, 0, 4'b1000, 1, 2'd3, 1, dat(3));
    add(0, 4'b1001, 4'b1001, 0, 4'b1000, 1, 2'd3, 1, dat(3));
    // Requester 2 burst, owner drops valid, then flush abandons it.
    add(0, 4'b0100, 4'b0000, 0, 4'b0100, 1, 2'd2, 0, dat(2));
    add(0, 4'b0001, 4'b0001, 0, 4'b0000, 0, 2'd2, 1, dat(2));
    add(1, 4'b0101, 4'b0001, 0, 4'b0000, 0, 2'd2, 1, dat(2));
    add(0, 4'b0101, 4'b0101, 0, 4'b0001, 1, 2'd0, 0, dat(0));
    // Pointer wrap 3 -> 0, then idle shows the pointer.
    add(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, 2'd3, 0, dat(3));
    add(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, 2'd0, 0, dat(0));
    add(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 2'd1, 0, 32'h0);

    for (int i = 0; i < NR; i++) bus.req_data_i[i] = dat(i);
    a_rst_n = 1'b0;
    drive(0, 4'b1111, 4'b1111, 0);
    #12;
    check_idle_outputs("reset_valid_held");
    drive(0, 4'b0000, 4'b0000, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    #2;
    check_idle_outputs("after_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].valid, vecs[i].last, vecs[i].full);
      #2;
      check($sformatf("v%0d.ready", i),  32'(bus.req_ready_o), 32'(vecs[i].ready));
      check($sformatf("v%0d.push", i),   32'(bus.fifo_push_o), 32'(vecs[i].push));
      check($sformatf("v%0d.grant", i),  32'(grant_idx),       32'(vecs[i].grant));
      check($sformatf("v%0d.locked", i), 32'(locked),          32'(vecs[i].locked));
      check($sformatf("v%0d.data", i),   bus.fifo_data_o,      vecs[i].data);
    end

    // Asynchronous reset in the middle of a requester 1 burst.
    @(negedge clk);
    drive(0, 4'b0010, 4'b0000, 0);
    #2;
    check("rst_mid.first_push", 32'(bus.fifo_push_o), 32'h1);
    @(negedge clk);
    #1;
    check("rst_mid.locked_before", 32'(locked), 32'h1);
    a_rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    drive(0, 4'b0000, 4'b0000, 0);
    a_rst_n = 1'b1;
    #2;
    check_idle_outputs("rst_mid_release");

`ifdef FIFO_ARB_STATS_EN
    for (int i = 0; i < NR; i++) check($sformatf("cnt_reset[%0d]", i), 32'(beat_cnt[i]), 32'h0);
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      drive(0, 4'b0010, 4'b0010, 0);
    end
    @(negedge clk);
    drive(1, 4'b0010, 4'b0010, 0);
    #2;
    check("cnt_flush.push", 32'(bus.fifo_push_o), 32'h0);
    @(negedge clk);
    drive(0, 4'b0000, 4'b0000, 0);
    #2;
    for (int i = 0; i < NR; i++)
      check($sformatf("cnt_after[%0d]", i), 32'(beat_cnt[i]), (i == 1) ? 32'd5 : 32'd0);
    a_rst_n = 1'b0;
    #1;
    check("cnt_cleared[1]", 32'(beat_cnt[1]), 32'h0);
    @(negedge clk);
    a_rst_n = 1'b1;
`endif

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin arbiter sharing the push port of one synchronous FIFO among `NUM_REQ` producers. Each producer offers data with a valid/ready handshake and may hold the FIFO for a multi-beat burst, delimited by `last`. The block sits directly in front of the FIFO's `push_i`/`data_i`/`full_o` and carries no storage beyond arbitration state.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: beat width; equals the FIFO data width.
- `IDX_WIDTH`, `$clog2(NUM_REQ)`: localparam, grant index width.

Ports:
- `clk` in 1: single clock.
- `a_rst_n` in 1: reset, asynchronous, active-low.
- `flush_i` in 1: synchronous pipeline flush, same-cycle as the FIFO flush.
- `req_valid_i` in `NUM_REQ`: per-requester beat valid.
- `req_last_i` in `NUM_REQ`: final beat of the requester's burst; a single beat has `last=1`.
- `req_data_i` in `NUM_REQ x DATA_WIDTH`: per-requester beat data.
- `req_ready_o` out `NUM_REQ`: beat accepted this cycle; one-hot or zero.
- `fifo_full_i` in 1: FIFO full flag.
- `fifo_push_o` out 1: FIFO push strobe.
- `fifo_data_o` out `DATA_WIDTH`: FIFO write data.
- `grant_idx_o` out `IDX_WIDTH`: index of the requester currently granted or locked.
- `locked_o` out 1: a burst is in progress.

## Operation
- State machine has two states.
  - IDLE: no owner.
  - LOCKED: owner register `own_q` holds the bus until its last beat.
- In IDLE, round-robin selection scans from `rr_ptr_q` upward, with wrap, for the first set `req_valid_i` bit.
  - A winner whose beat is accepted with `last=0` moves the block to LOCKED with `own_q` set to the winner.
  - A winner whose beat is accepted with `last=1` leaves the block in IDLE.
  - In both cases `rr_ptr_q` becomes winner+1, wrapping at `NUM_REQ`, but only after the final beat.
- In LOCKED, only `own_q` may transfer; other requesters see `ready=0`.
  - An accepted beat with `last=1` returns the block to IDLE and sets `rr_ptr_q` to `own_q`+1.
  - The owner deasserting valid mid-burst is legal; the lock is held.
- Acceptance condition: `fifo_push_o = |req_ready_o`, where `req_ready_o[i] = selected(i) & req_valid_i[i] & ~fifo_full_i & ~flush_i`.
- `fifo_data_o` is muxed from the selected requester. It is zero when no requester is selected.
- `grant_idx_o` shows the combinational winner in IDLE and `own_q` in LOCKED. When idle with no requests it shows `rr_ptr_q`.
- Full: no beat is accepted and no state changes. Arbitration is re-evaluated next cycle; a pending winner is not guaranteed the slot unless locked.
- Flush:
  - state goes to IDLE, `rr_ptr_q` to 0, `own_q` to 0;
  - no push occurs in the flush cycle;
  - any burst in progress is abandoned.
- Requesters must hold data and `last` stable while valid and not ready.

## Timing
- Reset values: state IDLE, `rr_ptr_q=0`, `own_q=0`, `locked_o=0`, `fifo_push_o=0`, `req_ready_o=0`, `fifo_data_o=0`, `grant_idx_o=0`.
- Arbitration is zero-latency: ready and push are combinational from valid, full and state in the same cycle.
- State, pointer and owner update on the rising edge after acceptance.
- Throughput is one beat per cycle, including the back-to-back transition from one requester's last beat to another requester's first beat.
- Reset asserted mid-burst clears all state immediately; there is no push while reset is asserted.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - adds output `beat_cnt_o`, `NUM_REQ x 16` bits, one counter per requester;
  - each counter increments on each accepted beat and saturates at 0xFFFF;
  - counters clear on reset only, not on flush.
- Undefined: the port and the counters are absent.

## Test plan
- `NUM_REQ=4`, all valid with single beats (`last=1`), FIFO never full -> grants in order 0,1,2,3,0 on consecutive cycles, with one push per cycle.
- Requester 1 sends a 3-beat burst while requesters 0 and 2 are valid -> beats from requester 1 only for 3 cycles with `locked_o=1`, then requester 2 is granted.
- `fifo_full_i=1` for 2 cycles during requester 3's burst -> `req_ready_o=0` and `fifo_push_o=0` for those cycles; the lock is held and the burst resumes on requester 3.
- Flush asserted mid-burst of requester 2 -> no push that cycle; next cycle IDLE with `rr_ptr=0`, so requester 0 wins if valid.
- Only requester 3 valid, then only requester 0 -> `rr_ptr` wraps 3 to 0; requester 0 is granted the next cycle.
- `FIFO_ARB_STATS_EN` defined, 5 beats from requester 1 -> `beat_cnt_o[1]=5`, others 0; the count is unchanged by flush and cleared by `a_rst_n`.
